// File: rtl/final_layer_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nn_parameters: shared sizes and FSM encoding for the final layer.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package nn_parameters;

  localparam int OUT_SIZE_4 = 3;
  localparam int SCORE_W    = 32;
  localparam int CLASS_W    = (OUT_SIZE_4 > 1) ? $clog2(OUT_SIZE_4) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } fl_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/final_layer_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | final_layer_sequencer_if: score input and result output handshake. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface final_layer_sequencer_if;
  import nn_parameters::*;

  logic                      start;
  logic                      busy;
  logic signed [SCORE_W-1:0] score_in;
  logic                      score_valid;
  logic                      score_ready;
  logic [CLASS_W-1:0]        class_out;
  logic signed [SCORE_W-1:0] max_score;
  logic                      out_valid;
  logic                      out_ready;
  logic                      low_conf;

  modport master (
    output start, score_in, score_valid, out_ready,
    input  busy, score_ready, class_out, max_score, out_valid, low_conf
  );

  modport slave (
    input  start, score_in, score_valid, out_ready,
    output busy, score_ready, class_out, max_score, out_valid, low_conf
  );

endinterface
`default_nettype wire

// File: rtl/final_layer_sequencer_score_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fl_score_buffer: class score store, one write port, async read.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fl_score_buffer #(
  parameter int DEPTH  = 3,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  // Contents are meaningless until loaded, so the array carries no reset.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/final_layer_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | final_layer_sequencer: buffers class scores, serial argmax scan.   |
// | Optional margin check: define FINAL_LAYER_MARGIN_EN.   Rev 1.0     |
// +--------------------------------------------------------------------+
module final_layer_sequencer
  import nn_parameters::*;
#(
  parameter int N_CLASSES = OUT_SIZE_4,
  parameter int MARGIN    = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  final_layer_sequencer_if.slave   bus
);

  localparam int               CNT_W    = $clog2(N_CLASSES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_CLASSES - 1);
  localparam logic [CNT_W-1:0] END_IDX  = CNT_W'(N_CLASSES);

  fl_seq_state_t             state, state_next;
  logic [CNT_W-1:0]          idx;
  logic signed [SCORE_W-1:0] rd_score;
  logic signed [SCORE_W-1:0] best_score;
  logic [CLASS_W-1:0]        best_idx;
  logic [CLASS_W-1:0]        class_q;
  logic signed [SCORE_W-1:0] max_q;
  logic                      low_q;
  logic                      low_next;
  logic                      accept;
  logic                      scan_step;
  logic                      take;

  assign accept    = (state == LOAD) && bus.score_valid;
  assign scan_step = (state == SCAN) && (idx != END_IDX);
  // Strictly greater keeps the lowest index on ties.
  assign take      = (idx == '0) || (rd_score > best_score);

  fl_score_buffer #(
    .DEPTH  (N_CLASSES),
    .WIDTH  (SCORE_W),
    .ADDR_W (CLASS_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (idx[CLASS_W-1:0]),
    .wr_data (bus.score_in),
    .rd_addr (idx[CLASS_W-1:0]),
    .rd_data (rd_score)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = LOAD;
      LOAD:    if (accept && (idx == LAST_IDX)) state_next = SCAN;
      SCAN:    if (idx == END_IDX) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx        <= '0;
      best_score <= '0;
      best_idx   <= '0;
      class_q    <= '0;
      max_q      <= '0;
      low_q      <= 1'b0;
    end else begin
      if ((state == IDLE) && bus.start) idx <= '0;
      else if (accept)    idx <= (idx == LAST_IDX) ? '0 : idx + CNT_W'(1);
      else if (scan_step) idx <= idx + CNT_W'(1);

      if (scan_step && take) begin
        best_score <= rd_score;
        best_idx   <= idx[CLASS_W-1:0];
      end

      if ((state == SCAN) && (idx == END_IDX)) begin
        class_q <= best_idx;
        max_q   <= best_score;
        low_q   <= low_next;
      end
    end
  end

`ifdef FINAL_LAYER_MARGIN_EN
  logic signed [SCORE_W-1:0] second_score;
  logic                      second_valid;
  logic signed [SCORE_W:0]   margin;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      second_score <= '0;
      second_valid <= 1'b0;
    end else if (scan_step) begin
      if (idx == '0) begin
        second_valid <= 1'b0;
      end else if (rd_score > best_score) begin
        second_score <= best_score;
        second_valid <= 1'b1;
      end else if (!second_valid || (rd_score > second_score)) begin
        second_score <= rd_score;
        second_valid <= 1'b1;
      end
    end
  end

  // One extra bit so best minus second cannot wrap.
  assign margin   = {best_score[SCORE_W-1], best_score} - {second_score[SCORE_W-1], second_score};
  assign low_next = (N_CLASSES > 1) && (margin < $signed((SCORE_W + 1)'(MARGIN)));
`else
  // MARGIN has no effect here; referenced only so it is not left dangling.
  assign low_next = 1'b0 && (MARGIN >= 0);
`endif

  assign bus.busy        = (state != IDLE);
  assign bus.score_ready = (state == LOAD);
  assign bus.out_valid   = (state == DONE);
  assign bus.class_out   = class_q;
  assign bus.max_score   = max_q;
  assign bus.low_conf    = low_q;

endmodule
`default_nettype wire

// File: tb/tb_final_layer_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_final_layer_sequencer: directed vectors against an argmax model.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_final_layer_sequencer;
  import nn_parameters::*;

  typedef logic signed [31:0] trip_t [3];

`ifdef FINAL_LAYER_MARGIN_EN
  localparam bit MEN = 1'b1;
`else
  localparam bit MEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_results = 0;
  int   n_starts = 0;

  logic [CLASS_W-1:0]        exp_class = '0;
  logic signed [SCORE_W-1:0] exp_score = '0;
  logic                      exp_low   = 1'b0;

  final_layer_sequencer_if bus();

  final_layer_sequencer #(
    .N_CLASSES (OUT_SIZE_4),
    .MARGIN    (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Argmax by value: find the maximum, then the first index holding it;
  // the runner-up is the largest value among the other indices.
  function automatic void model(input trip_t s, output int cls,
                                output logic signed [31:0] mx, output logic low);
    logic signed [31:0] sec;
    longint             margin;
    bit                 have_sec;
    mx = s[0];
    for (int i = 1; i < 3; i++) if (s[i] > mx) mx = s[i];
    cls = 0;
    for (int i = 2; i >= 0; i--) if (s[i] == mx) cls = i;
    sec = 0;
    have_sec = 0;
    for (int i = 0; i < 3; i++)
      if (i != cls && (!have_sec || s[i] > sec)) begin sec = s[i]; have_sec = 1; end
    margin = longint'(mx) - longint'(sec);
    low = MEN && (margin < 10);
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1 && bus.out_valid === 1'b1) begin
      check("model_class", 64'(bus.class_out), 64'(exp_class));
      check("model_score", 64'(bus.max_score), 64'(exp_score));
      check("model_low",   64'(bus.low_conf),  64'(exp_low));
      if (bus.out_ready) n_results++;
    end
  end

  task automatic send(input trip_t s, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      bit acc;
      int b;
      if (gaps) begin
        bus.score_valid = 1'b0;
        bus.score_in    = 32'sh7FFF_FFFF;
        @(posedge clk); #1;
      end
      bus.score_valid = 1'b1;
      bus.score_in    = s[i];
      acc = 1'b0;
      b   = 0;
      while (!acc && b < 20) begin
        @(negedge clk); acc = bus.score_ready;
        @(posedge clk); #1; b++;
      end
      if (!acc) check("accept_timeout", 64'd0, 64'd1);
    end
    bus.score_valid = 1'b0;
  endtask

  task automatic run_infer(input trip_t s, input int exp_c, input logic signed [31:0] exp_m,
                           input logic exp_l, input bit gaps, input int hold,
                           input bit spurious, input string tag);
    int                 c;
    logic signed [31:0] m;
    logic               l;
    int                 edges;
    model(s, c, m, l);
    exp_class = CLASS_W'(c);
    exp_score = m;
    exp_low   = l;
    check({tag, "_pin_cls"}, 64'(c), 64'(exp_c));
    check({tag, "_pin_max"}, 64'(m), 64'(exp_m));
    bus.out_ready = (hold == 0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = spurious;
    n_starts++;
    send(s, 3, gaps);
    check({tag, "_ready_scan"}, 64'(bus.score_ready), 64'd0);
    edges = 0;
    while (!bus.out_valid && edges < 20) begin
      @(posedge clk); #1; edges++;
    end
    check({tag, "_latency"}, 64'(edges), 64'd4);
    check({tag, "_class"}, 64'(bus.class_out), 64'(exp_c));
    check({tag, "_max"},   64'(bus.max_score), 64'(exp_m));
    check({tag, "_low"},   64'(bus.low_conf),  64'(exp_l));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, "_hold_class"}, 64'(bus.class_out), 64'(exp_c));
      check({tag, "_hold_max"},   64'(bus.max_score), 64'(exp_m));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    check({tag, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_busy_drop"},  64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    check({tag, "_still_idle"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    trip_t t;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.score_valid = 1'b0;
    bus.score_in = '0;
    bus.out_ready = 1'b0;
    #12;
    check("rst_busy",  64'(bus.busy), 64'd0);
    check("rst_ready", 64'(bus.score_ready), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_class", 64'(bus.class_out), 64'd0);
    check("rst_max",   64'(bus.max_score), 64'd0);
    check("rst_low",   64'(bus.low_conf), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Scores offered while idle must be refused.
    bus.score_valid = 1'b1;
    bus.score_in = 32'sd123;
    repeat (2) begin
      @(posedge clk); #1;
      check("idle_ready", 64'(bus.score_ready), 64'd0);
      check("idle_busy",  64'(bus.busy), 64'd0);
    end
    bus.score_valid = 1'b0;

    t = '{32'sd500, 32'sd300000, 32'sd2000000};
    run_infer(t, 2, 32'sd2000000, 1'b0, 0, 0, 0, "basic");
    t = '{32'sd7, 32'sd7, -32'sd3};
    run_infer(t, 0, 32'sd7, MEN, 0, 0, 0, "tie");
    t = '{32'sh8000_0000, 32'sh7FFF_FFFF, 32'sd0};
    run_infer(t, 1, 32'sh7FFF_FFFF, 1'b0, 0, 0, 0, "extreme");
    t = '{32'sd10, -32'sd20, 32'sd30};
    run_infer(t, 2, 32'sd30, 1'b0, 1, 10, 0, "backpr");
    t = '{32'sd3, 32'sd8, 32'sd8};
    run_infer(t, 1, 32'sd8, MEN, 0, 0, 1, "spurious");
    t = '{-32'sd5, -32'sd1, -32'sd9};
    run_infer(t, 1, -32'sd1, MEN, 0, 0, 0, "neg");

    // Abort after two of three scores; outputs must clear between edges.
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    t = '{32'sd1000, 32'sd2000, 32'sd3000};
    send(t, 2, 0);
    #2 rst = 1'b0;
    #1;
    check("abort_busy",  64'(bus.busy), 64'd0);
    check("abort_ready", 64'(bus.score_ready), 64'd0);
    check("abort_valid", 64'(bus.out_valid), 64'd0);
    check("abort_class", 64'(bus.class_out), 64'd0);
    check("abort_max",   64'(bus.max_score), 64'd0);
    check("abort_low",   64'(bus.low_conf), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    t = '{32'sd1, 32'sd9, 32'sd3};
    run_infer(t, 1, 32'sd9, MEN, 0, 0, 0, "fresh");

    t = '{32'sd100, 32'sd105, 32'sd0};
    run_infer(t, 1, 32'sd105, MEN, 0, 0, 0, "mrg_close");
    t = '{32'sd100, 32'sd200, 32'sd0};
    run_infer(t, 1, 32'sd200, 1'b0, 0, 0, 0, "mrg_wide");
    t = '{32'sd50, 32'sd50, 32'sd0};
    run_infer(t, 0, 32'sd50, MEN, 0, 0, 0, "mrg_tie");

    repeat (3) @(posedge clk);
    #1;
    check("result_count", 64'(n_results), 64'(n_starts));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/final_layer_sequencer.md
Name: final_layer_sequencer

Overview:
Controller in front of the final classification stage. It accepts the OUT_SIZE_4 signed class scores serially from the last dense layer over a valid/ready handshake and buffers them. It then runs a one-element-per-cycle argmax scan and presents the winning class index, with its score, on an output valid/ready handshake. It serialises the final layer so that one comparator serves every class.

Parameters:
N_CLASSES, OUT_SIZE_4 (3), number of class scores per inference
SCORE_W, 32, signed score width
CLASS_W, 2, class index width; must satisfy 2**CLASS_W >= N_CLASSES
MARGIN, 1000, minimum best-minus-second-best difference (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse that begins an inference
busy  out  1  high in every state except IDLE
score_in  in  SCORE_W  signed class score; arrives in class order 0..N_CLASSES-1
score_valid  in  1  score_in is valid
score_ready  out  1  block accepts a score this cycle
class_out  out  CLASS_W  index of the winning class
max_score  out  SCORE_W  score of the winning class
out_valid  out  1  result valid; held until accepted
out_ready  in  1  downstream accepts the result
low_conf  out  1  winner margin is below MARGIN (optional feature)

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, all counters = 0.
  - class_out = 0, max_score = 0, out_valid = 0, score_ready = 0, busy = 0, low_conf = 0.
  - Buffer contents are don't-care.
- FSM states: IDLE, LOAD, SCAN, DONE.
- IDLE:
  - start=1 -> LOAD, with load index = 0.
  - score_valid is ignored in IDLE; score_ready = 0.
- LOAD:
  - score_ready = 1.
  - Each cycle with score_valid&score_ready writes buffer[idx] and increments idx.
  - On acceptance of score N_CLASSES-1 -> SCAN, with scan index = 0.
- SCAN:
  - score_ready = 0.
  - One buffer entry is compared per cycle, as a signed comparison.
  - Index 0 initialises best.
  - A later entry replaces best only if it is strictly greater, so ties keep the lowest index.
  - After entry N_CLASSES-1 -> DONE.
  - class_out and max_score are registered on the DONE entry edge.
- Latency: out_valid rises exactly N_CLASSES+1 rising edges after the edge that accepted the last score.
- DONE:
  - out_valid = 1.
  - class_out, max_score and low_conf are stable until the handshake.
  - out_valid&out_ready -> IDLE; out_valid drops on the next cycle.
  - class_out and max_score keep their last values while idle.
- start asserted in any state other than IDLE is ignored and is not queued.
- start and out_ready high together in DONE: the start is ignored.
- Gaps in score_valid during LOAD stall the block with no timeout.
- Reset asserted mid-LOAD or mid-SCAN aborts the inference immediately. No out_valid is produced for it.
- Arithmetic: all scores are signed two's complement. Comparisons use the full SCORE_W; no saturation is applied.

Optional Feature:
Macro FINAL_LAYER_MARGIN_EN.
- With the macro defined:
  - The scan also tracks the second-best score.
  - margin = best - second, computed in SCORE_W+1 bits.
  - low_conf = (margin < MARGIN), registered together with class_out.
  - A tie gives margin 0, so low_conf = 1 whenever MARGIN > 0.
  - For N_CLASSES = 1, low_conf = 0.
- Without the macro: low_conf is tied to 0 and no second-best logic is generated.

Decomposition:
- Package nn_parameters holds:
  - OUT_SIZE_4
  - SCORE_W
  - CLASS_W, derived via $clog2 and minimum 1
  - the FSM state enum typedef fl_seq_state_t
- One sub-module, fl_score_buffer: an N_CLASSES x SCORE_W register array with a single write port and a single asynchronous read port, indexed by the scan counter.
- The FSM, counters and comparator stay in final_layer_sequencer.

Test Plan:
- Basic winner: start, then scores {500, 300000, 2000000} sent back-to-back, out_ready=1.
  - Required: class_out=2, max_score=2000000.
  - out_valid rises 4 edges after the last score is accepted; busy falls the cycle after the handshake.
- Ties and negatives:
  - {7, 7, -3} -> class_out=0, max_score=7.
  - {-5, -1, -9} -> class_out=1, max_score=-1.
  - {-2147483648, 2147483647, 0} -> class_out=1.
- Backpressure:
  - score_valid toggles 1/0 during LOAD; out_ready is held 0 for 10 cycles in DONE.
  - Required: only valid scores are counted; out_valid, class_out and max_score stay stable for all 10 cycles.
  - Single out_valid&out_ready transfer at cycle 11, then IDLE.
- Spurious start:
  - Start pulses issued during LOAD, SCAN and DONE.
  - Required: no effect, and exactly one result per accepted start.
- Reset mid-operation: rst driven low after 2 of 3 scores.
  - Required: all outputs at reset values immediately, including asynchronously between clock edges.
  - A fresh inference {1, 9, 3} then yields class_out=1.
- FINAL_LAYER_MARGIN_EN with MARGIN=10:
  - {100, 105, 0} -> class_out=1, low_conf=1.
  - {100, 200, 0} -> low_conf=0.
  - {50, 50, 0} -> class_out=0, low_conf=1.
  - With the macro undefined, low_conf=0 for all three cases.
